// File: rtl/pwmcfg_update_ctrl.sv
// ---------------------------------------------------------------------------
// pwmcfg_update_ctrl
//
// Update sequencer for the PWM configuration word. It sits between the
// register bank and the PWM datapath. A new word is captured in a shadow
// register and copied to the live word (cfg_active) only at a safe carrier
// event, on an explicit force, or after a timeout. Switching the PWM on
// (bit5 0->1) pulses cnt_clr so that every enable starts counting from zero.
//
// Config word bits:
//   0 count_mode, 1 mask_mode, 2 dtclkdiv_onoff, 3 pwmclkdiv_onoff,
//   4 int_onoff, 5 pwm_onoff, 6 logic_A, 7 logic_B
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   cfg_wdata        new config word
//   cfg_wvalid       write request
//   cfg_wready       shadow can accept a word (low only in APPLY)
//   upd_mode         00 immediate, 01 zero event, 10 period event, 11 either
//   evt_zero         1-cycle pulse, carrier counter at zero
//   evt_period       1-cycle pulse, carrier counter at period
//   force_apply      commit a pending word on the next edge
//   ovr_clr          clear ovr_sticky
//   cfg_active       live config word (registered)
//   cnt_clr          1-cycle counter clear on a pwm_onoff 0->1 commit
//   upd_done         1-cycle pulse when the new cfg_active is first visible
//   to_pulse         1-cycle pulse with upd_done when the timeout forced it
//   busy             high in PENDING or APPLY
//   ovr_sticky       a pending word was overwritten before being committed
//   dbg_state        current FSM state (IDLE=0, PENDING=1, APPLY=2)
//
// Handshake: a word is transferred on a rising clk edge where both
// cfg_wvalid and cfg_wready are high; cfg_wdata is sampled on that edge.
// cfg_wvalid may be held or dropped freely; a word offered while cfg_wready
// is low is simply not taken.
// ---------------------------------------------------------------------------
module pwmcfg_update_ctrl #(
  parameter int CFG_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TO_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CFG_WIDTH-1:0] cfg_wdata,
  input  logic                 cfg_wvalid,
  output logic                 cfg_wready,
  input  logic [1:0]           upd_mode,
  input  logic                 evt_zero,
  input  logic                 evt_period,
  input  logic                 force_apply,
  input  logic                 ovr_clr,
  output logic [CFG_WIDTH-1:0] cfg_active,
  output logic                 cnt_clr,
  output logic                 upd_done,
  output logic                 to_pulse,
  output logic                 busy,
  output logic                 ovr_sticky,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_APPLY   = 2'd2
  } state_e;

  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam int PWM_ON_BIT = 5;

  state_e               state_q, state_d;
  logic [CFG_WIDTH-1:0] shadow_q, shadow_d;
  logic [CFG_WIDTH-1:0] cfg_active_q, cfg_active_d;
  logic [TO_WIDTH-1:0]  to_cnt_q, to_cnt_d;
  logic                 to_cause_q, to_cause_d;
  logic                 cnt_clr_q, cnt_clr_d;
  logic                 upd_done_q, upd_done_d;
  logic                 to_pulse_q, to_pulse_d;
  logic                 ovr_q, ovr_d;

  logic accept;
  logic evt_match;
  logic to_hit;

  assign cfg_wready = (state_q != ST_APPLY);
  assign busy       = (state_q != ST_IDLE);
  assign dbg_state  = state_q;

  assign cfg_active = cfg_active_q;
  assign cnt_clr    = cnt_clr_q;
  assign upd_done   = upd_done_q;
  assign to_pulse   = to_pulse_q;
  assign ovr_sticky = ovr_q;

  assign accept = cfg_wvalid & cfg_wready;
  // Mode 00 counts as an always-present event so that switching to
  // immediate mode while PENDING commits on the next edge.
  assign evt_match = (upd_mode == 2'b00)
                   | (upd_mode[0] & evt_zero)
                   | (upd_mode[1] & evt_period);
  assign to_hit = (to_cnt_q == TO_LAST);

  always_comb begin
    state_d      = state_q;
    shadow_d     = accept ? cfg_wdata : shadow_q;
    cfg_active_d = cfg_active_q;
    to_cnt_d     = to_cnt_q;
    to_cause_d   = to_cause_q;
    cnt_clr_d    = 1'b0;
    upd_done_d   = 1'b0;
    to_pulse_d   = 1'b0;
    // Overwrite of a pending word takes priority over the clear request.
    if (accept && state_q == ST_PENDING) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end

    unique case (state_q)
      ST_IDLE: begin
        // Events and force are ignored here; an event coinciding with the
        // accept is not consumed.
        if (accept) begin
          to_cause_d = 1'b0;
          if (upd_mode == 2'b00 || !cfg_active_q[PWM_ON_BIT]) begin
            // PWM stopped: no carrier events will come, commit directly.
            state_d = ST_APPLY;
          end else begin
            state_d  = ST_PENDING;
            to_cnt_d = '0;
          end
        end
      end
      ST_PENDING: begin
        // An overwrite here does not restart the timeout.
        to_cnt_d = to_cnt_q + TO_WIDTH'(1);
        if (evt_match || force_apply) begin
          state_d    = ST_APPLY;
          to_cause_d = 1'b0;
        end else if (to_hit) begin
          state_d    = ST_APPLY;
          to_cause_d = 1'b1;
        end
      end
      ST_APPLY: begin
        cfg_active_d = shadow_q;
        upd_done_d   = 1'b1;
        cnt_clr_d    = ~cfg_active_q[PWM_ON_BIT] & shadow_q[PWM_ON_BIT];
        to_pulse_d   = to_cause_q;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      shadow_q     <= '0;
      cfg_active_q <= '0;
      to_cnt_q     <= '0;
      to_cause_q   <= 1'b0;
      cnt_clr_q    <= 1'b0;
      upd_done_q   <= 1'b0;
      to_pulse_q   <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      cfg_active_q <= cfg_active_d;
      to_cnt_q     <= to_cnt_d;
      to_cause_q   <= to_cause_d;
      cnt_clr_q    <= cnt_clr_d;
      upd_done_q   <= upd_done_d;
      to_pulse_q   <= to_pulse_d;
      ovr_q        <= ovr_d;
    end
  end

endmodule

// File: tb/tb_pwmcfg_update_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pwmcfg_update_ctrl
//
// Directed bench for pwmcfg_update_ctrl with TIMEOUT_CYCLES=8. A table of
// per-edge input/expected-output records covers immediate, zero-event,
// period-event, overwrite, force and disable sequences; hand-written
// sequences cover the timeout commit and a reset in the middle of PENDING.
// Inputs are driven right after a rising edge; outputs are sampled 1 time
// unit after the next rising edge.
// ---------------------------------------------------------------------------
module tb_pwmcfg_update_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] cfg_wdata;
  logic         cfg_wvalid;
  logic         cfg_wready;
  logic [1:0]   upd_mode;
  logic         evt_zero;
  logic         evt_period;
  logic         force_apply;
  logic         ovr_clr;
  logic [W-1:0] cfg_active;
  logic         cnt_clr;
  logic         upd_done;
  logic         to_pulse;
  logic         busy;
  logic         ovr_sticky;
  logic [1:0]   dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  pwmcfg_update_ctrl #(
    .CFG_WIDTH      (W),
    .TIMEOUT_CYCLES (8),
    .TO_WIDTH       (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_wdata   (cfg_wdata),
    .cfg_wvalid  (cfg_wvalid),
    .cfg_wready  (cfg_wready),
    .upd_mode    (upd_mode),
    .evt_zero    (evt_zero),
    .evt_period  (evt_period),
    .force_apply (force_apply),
    .ovr_clr     (ovr_clr),
    .cfg_active  (cfg_active),
    .cnt_clr     (cnt_clr),
    .upd_done    (upd_done),
    .to_pulse    (to_pulse),
    .busy        (busy),
    .ovr_sticky  (ovr_sticky),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vector record ----------------
  typedef struct {
    logic         wv;
    logic [W-1:0] wd;
    logic [1:0]   mode;
    logic         ez;
    logic         ep;
    logic         frc;
    logic         oc;
    logic [W-1:0] e_act;
    logic         e_done;
    logic         e_clr;
    logic         e_to;
    logic         e_busy;
    logic         e_wr;
    logic         e_ovr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic wv, input logic [W-1:0] wd,
                              input logic [1:0] mode, input logic ez,
                              input logic ep, input logic frc, input logic oc,
                              input logic [W-1:0] act, input logic done,
                              input logic clr, input logic to, input logic bsy,
                              input logic wr, input logic ovr);
    vec_t v;
    v.wv = wv; v.wd = wd; v.mode = mode; v.ez = ez; v.ep = ep;
    v.frc = frc; v.oc = oc; v.e_act = act; v.e_done = done; v.e_clr = clr;
    v.e_to = to; v.e_busy = bsy; v.e_wr = wr; v.e_ovr = ovr;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic wv, input logic [W-1:0] wd,
                       input logic [1:0] mode, input logic ez, input logic ep,
                       input logic frc, input logic oc);
    cfg_wvalid  = wv;
    cfg_wdata   = wd;
    upd_mode    = mode;
    evt_zero    = ez;
    evt_period  = ep;
    force_apply = frc;
    ovr_clr     = oc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, " cfg_active"}, cfg_active, v.e_act);
    chk({tag, " upd_done"}, W'(upd_done), W'(v.e_done));
    chk({tag, " cnt_clr"}, W'(cnt_clr), W'(v.e_clr));
    chk({tag, " to_pulse"}, W'(to_pulse), W'(v.e_to));
    chk({tag, " busy"}, W'(busy), W'(v.e_busy));
    chk({tag, " cfg_wready"}, W'(cfg_wready), W'(v.e_wr));
    chk({tag, " ovr_sticky"}, W'(ovr_sticky), W'(v.e_ovr));
  endtask

  // ---------------- test ----------------
  initial begin
    //                wv  wd     md ez ep fr oc | act  dn cl to by wr ov
    // immediate commit of a PWM enable
    tbl.push_back(mk(1, 8'h20, 0, 0, 0, 0, 0,  8'h00, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0,  8'h20, 1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0,  8'h20, 0, 0, 0, 0, 1, 0));
    // zero-event mode; period event ignored
    tbl.push_back(mk(1, 8'h21, 1, 0, 0, 0, 0,  8'h20, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0,  8'h20, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0,  8'h20, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0,  8'h20, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0,  8'h21, 1, 0, 0, 0, 1, 0));
    // period-event mode with overwrite, then ovr_clr
    tbl.push_back(mk(1, 8'h23, 2, 0, 0, 0, 0,  8'h21, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 8'h27, 2, 0, 0, 0, 0,  8'h21, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 8'h00, 2, 1, 0, 0, 0,  8'h21, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 8'h00, 2, 0, 1, 0, 0,  8'h21, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 8'h00, 2, 0, 0, 0, 0,  8'h27, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 8'h00, 2, 0, 0, 0, 1,  8'h27, 0, 0, 0, 0, 1, 0));
    // overwrite coinciding with the event (and with ovr_clr: set wins)
    tbl.push_back(mk(1, 8'h2A, 1, 0, 0, 0, 0,  8'h27, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 8'h2B, 1, 1, 0, 0, 1,  8'h27, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0,  8'h2B, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1,  8'h2B, 0, 0, 0, 0, 1, 0));
    // force_apply in PENDING
    tbl.push_back(mk(1, 8'h2C, 3, 0, 0, 0, 0,  8'h2B, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 8'h00, 3, 0, 0, 1, 0,  8'h2B, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 3, 0, 0, 0, 0,  8'h2C, 1, 0, 0, 0, 1, 0));
    // disable waits for the event, no cnt_clr
    tbl.push_back(mk(1, 8'h0C, 1, 0, 0, 0, 0,  8'h2C, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0,  8'h2C, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0,  8'h0C, 1, 0, 0, 0, 1, 0));
    // PWM stopped: event mode commits directly, enable gives cnt_clr
    tbl.push_back(mk(1, 8'h25, 1, 0, 0, 0, 0,  8'h0C, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0,  8'h25, 1, 1, 0, 0, 1, 0));
    // events and force ignored in IDLE
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 1, 0,  8'h25, 0, 0, 0, 0, 1, 0));
    // write offered during APPLY is not taken
    tbl.push_back(mk(1, 8'h30, 0, 0, 0, 0, 0,  8'h25, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 8'h31, 0, 0, 0, 0, 0,  8'h30, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0,  8'h30, 0, 0, 0, 0, 1, 0));
    // mode switched to 00 while PENDING commits next edge
    tbl.push_back(mk(1, 8'h32, 1, 0, 0, 0, 0,  8'h30, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0,  8'h30, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0,  8'h32, 1, 0, 0, 0, 1, 0));

    // ---- reset ----
    rst_n = 1'b0;
    drive(0, 8'h00, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset cfg_active", cfg_active, 8'h00);
    chk("reset upd_done", W'(upd_done), 8'h00);
    chk("reset cnt_clr", W'(cnt_clr), 8'h00);
    chk("reset to_pulse", W'(to_pulse), 8'h00);
    chk("reset busy", W'(busy), 8'h00);
    chk("reset ovr_sticky", W'(ovr_sticky), 8'h00);
    chk("reset cfg_wready", W'(cfg_wready), 8'h01);
    chk("reset dbg_state", W'(dbg_state), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- table ----
    foreach (tbl[i]) begin
      drive(tbl[i].wv, tbl[i].wd, tbl[i].mode, tbl[i].ez, tbl[i].ep,
            tbl[i].frc, tbl[i].oc);
      step();
      chk_all($sformatf("v%0d", i), tbl[i]);
    end

    // ---- timeout: accept 0x33, overwrite with 0x34 three edges later ----
    drive(1, 8'h33, 3, 0, 0, 0, 0);
    step();
    chk("to entry busy", W'(busy), 8'h01);
    for (int i = 1; i <= 9; i++) begin
      if (i == 3) drive(1, 8'h34, 3, 0, 0, 0, 0);
      else        drive(0, 8'h00, 3, 0, 0, 0, 0);
      step();
      if (i < 9) begin
        chk($sformatf("to e%0d upd_done", i), W'(upd_done), 8'h00);
        chk($sformatf("to e%0d cfg_active", i), cfg_active, 8'h32);
        chk($sformatf("to e%0d busy", i), W'(busy), 8'h01);
      end
      if (i == 3) chk("to overwrite ovr_sticky", W'(ovr_sticky), 8'h01);
      if (i == 8) chk("to apply cfg_wready", W'(cfg_wready), 8'h00);
    end
    chk("to commit cfg_active", cfg_active, 8'h34);
    chk("to commit upd_done", W'(upd_done), 8'h01);
    chk("to commit to_pulse", W'(to_pulse), 8'h01);
    chk("to commit cnt_clr", W'(cnt_clr), 8'h00);
    drive(0, 8'h00, 3, 0, 0, 0, 1);
    step();
    chk("to after to_pulse", W'(to_pulse), 8'h00);
    chk("to after ovr_sticky", W'(ovr_sticky), 8'h00);

    // ---- reset in the middle of PENDING ----
    drive(1, 8'h35, 1, 0, 0, 0, 0);
    step();
    drive(1, 8'h36, 1, 0, 0, 0, 0);
    step();
    chk("pre-rst busy", W'(busy), 8'h01);
    chk("pre-rst ovr_sticky", W'(ovr_sticky), 8'h01);
    drive(0, 8'h00, 1, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid-rst cfg_active", cfg_active, 8'h00);
    chk("mid-rst busy", W'(busy), 8'h00);
    chk("mid-rst ovr_sticky", W'(ovr_sticky), 8'h00);
    chk("mid-rst upd_done", W'(upd_done), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post-rst cfg_wready", W'(cfg_wready), 8'h01);
    chk("post-rst busy", W'(busy), 8'h00);
    chk("post-rst cfg_active", cfg_active, 8'h00);
    // PWM is off again, so an event-mode enable commits directly
    drive(1, 8'h20, 1, 0, 0, 0, 0);
    step();
    drive(0, 8'h00, 1, 0, 0, 0, 0);
    step();
    chk("post-rst commit cfg_active", cfg_active, 8'h20);
    chk("post-rst commit cnt_clr", W'(cnt_clr), 8'h01);
    chk("post-rst commit upd_done", W'(upd_done), 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
